// File: rtl/uart_msg_scheduler_if.sv
// rtl/uart_msg_scheduler_if.sv - transmit handshake between the scheduler and uart_tx
interface uart_msg_scheduler_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_msg_scheduler.sv
// rtl/uart_msg_scheduler.sv - shares one uart_tx between sync markers and buffered edit events
// Optional byte escaping of SYNC_BYTE/ESC_BYTE events: define UART_MSG_SCHEDULER_ESCAPE_EN.
module uart_msg_scheduler #(
   parameter int                    FIFO_DEPTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hFF,
   parameter logic [DATA_WIDTH-1:0] ESC_BYTE   = 8'hFE
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                i_sync_req,
   input  logic                                i_evt_valid,
   input  logic [DATA_WIDTH-1:0]               i_evt_data,
   input  logic                                i_clr_status,
   uart_msg_scheduler_if.master                tx_if,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_fifo_count,
   output logic                                o_overflow,
   output logic [7:0]                          o_drop_count,
   output logic                                o_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_ESC2 = 2'd2
   } state_t;

   // Elaboration-time parameter sanity
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end
   if (ESC_BYTE == SYNC_BYTE) begin : g_bad_esc
      $error("ESC_BYTE must differ from SYNC_BYTE");
   end

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_sync_pending;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_valid;
   logic                  r_overflow;
   logic [7:0]            r_drop_count;

   logic [DATA_WIDTH-1:0] w_tx_data_nxt;
   logic                  w_tx_valid_nxt;
   logic                  w_pop;
   logic                  w_sync_clr;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_head;

`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
   localparam logic [DATA_WIDTH-1:0] ESC_XOR = DATA_WIDTH'(32'h20);
   logic                  r_esc_flag;
   logic [DATA_WIDTH-1:0] r_esc_data;
   logic                  w_esc_flag_nxt;
   logic [DATA_WIDTH-1:0] w_esc_data_nxt;
`endif

   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign w_push  = i_evt_valid && (!w_full || w_pop);
   assign w_drop  = i_evt_valid && !w_push;

   // Arbitration only happens in IDLE; an in-flight byte is never preempted
   always_comb begin
      w_state_nxt    = r_state;
      w_tx_data_nxt  = r_tx_data;
      w_tx_valid_nxt = r_tx_valid;
      w_pop          = 1'b0;
      w_sync_clr     = 1'b0;
`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
      w_esc_flag_nxt = r_esc_flag;
      w_esc_data_nxt = r_esc_data;
`endif
      case (r_state)
         ST_IDLE: begin
            if (r_sync_pending) begin
               w_tx_data_nxt  = SYNC_BYTE;
               w_tx_valid_nxt = 1'b1;
               w_sync_clr     = 1'b1;
               w_state_nxt    = ST_SEND;
            end else if (!w_empty) begin
               w_pop          = 1'b1;
               w_tx_valid_nxt = 1'b1;
               w_state_nxt    = ST_SEND;
`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
               if (w_head == SYNC_BYTE || w_head == ESC_BYTE) begin
                  w_tx_data_nxt  = ESC_BYTE;
                  w_esc_flag_nxt = 1'b1;
                  w_esc_data_nxt = w_head ^ ESC_XOR;
               end else begin
                  w_tx_data_nxt  = w_head;
               end
`else
               w_tx_data_nxt  = w_head;
`endif
            end
         end
         ST_SEND: begin
            if (r_tx_valid && tx_if.tx_ready) begin
               w_tx_valid_nxt = 1'b0;
`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
               if (r_esc_flag) begin
                  w_esc_flag_nxt = 1'b0;
                  w_state_nxt    = ST_ESC2;
               end else begin
                  w_state_nxt    = ST_IDLE;
               end
`else
               w_state_nxt    = ST_IDLE;
`endif
            end
         end
         ST_ESC2: begin
`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
            // Second half of an escape pair; sync cannot slip in here
            w_tx_data_nxt  = r_esc_data;
            w_tx_valid_nxt = 1'b1;
            w_state_nxt    = ST_SEND;
`else
            w_state_nxt    = ST_IDLE;
`endif
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state and registered transmit outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
         r_esc_flag <= 1'b0;
         r_esc_data <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= w_tx_valid_nxt;
`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
         r_esc_flag <= w_esc_flag_nxt;
         r_esc_data <= w_esc_data_nxt;
`endif
      end
   end

   // Event storage; contents need no reset because occupancy is tracked separately
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_evt_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sync capture; repeated requests while pending coalesce into one marker
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync_pending <= 1'b0;
      end else if (i_sync_req) begin
         r_sync_pending <= 1'b1;
      end else if (w_sync_clr) begin
         r_sync_pending <= 1'b0;
      end
   end

   // Drop status; a drop coinciding with clear restarts the count at one
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_overflow   <= 1'b0;
         r_drop_count <= 8'd0;
      end else if (w_drop) begin
         r_overflow   <= 1'b1;
         if (i_clr_status)              r_drop_count <= 8'd1;
         else if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      end else if (i_clr_status) begin
         r_overflow   <= 1'b0;
         r_drop_count <= 8'd0;
      end
   end

   assign tx_if.tx_data  = r_tx_data;
   assign tx_if.tx_valid = r_tx_valid;
   assign o_fifo_count   = r_count;
   assign o_overflow     = r_overflow;
   assign o_drop_count   = r_drop_count;
   assign o_busy         = (r_state != ST_IDLE) || r_sync_pending || !w_empty;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// tb/tb_uart_msg_scheduler.sv - randomized and directed bench for uart_msg_scheduler
module tb_uart_msg_scheduler;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rstn;
   logic          sync_req, evt_valid, clr;
   logic [7:0]    evt_data;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic [7:0]    drop_count;
   logic          busy;

   uart_msg_scheduler_if #(.DATA_WIDTH(8)) u_if ();

   uart_msg_scheduler #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(8)) u_dut (
      .clk          (clk),
      .rstn         (rstn),
      .i_sync_req   (sync_req),
      .i_evt_valid  (evt_valid),
      .i_evt_data   (evt_data),
      .i_clr_status (clr),
      .tx_if        (u_if),
      .o_fifo_count (fifo_count),
      .o_overflow   (overflow),
      .o_drop_count (drop_count),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: queue of events, pending sync flag, byte on the wire
   logic [7:0] m_q[$];
   logic [7:0] exp_wire[$];
   logic [7:0] dut_wire[$];
   bit         m_sync, m_valid, m_esc2, m_esc_pend, m_ovf;
   logic [7:0] m_cur, m_esc_byte, m_drops;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_sync = 0; m_valid = 0; m_esc2 = 0; m_esc_pend = 0; m_ovf = 0;
      m_cur = 0; m_esc_byte = 0; m_drops = 0;
   endtask

   task automatic model_edge();
      logic [7:0] b;
      bit drop;
      if (m_valid) begin
         if (u_if.tx_ready) begin
            exp_wire.push_back(m_cur);
            m_valid = 0;
            if (m_esc_pend) begin m_esc2 = 1; m_esc_pend = 0; end
         end
      end else if (m_esc2) begin
         m_cur = m_esc_byte; m_valid = 1; m_esc2 = 0;
      end else if (m_sync) begin
         m_cur = 8'hFF; m_valid = 1; m_sync = 0;
      end else if (m_q.size() != 0) begin
         b = m_q.pop_front();
         m_valid = 1;
`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
         if (b == 8'hFF || b == 8'hFE) begin
            m_cur = 8'hFE; m_esc_pend = 1; m_esc_byte = b ^ 8'h20;
         end else m_cur = b;
`else
         m_cur = b;
`endif
      end
      if (sync_req) m_sync = 1;
      drop = evt_valid && (m_q.size() >= DEPTH);
      if (evt_valid && !drop) m_q.push_back(evt_data);
      if (drop) begin
         m_ovf = 1;
         m_drops = clr ? 8'd1 : ((m_drops == 8'hFF) ? 8'hFF : m_drops + 8'd1);
      end else if (clr) begin
         m_ovf = 0; m_drops = 0;
      end
   endtask

   task automatic check_outputs();
      check_eq("tx_valid", u_if.tx_valid, m_valid);
      if (m_valid) check_eq("tx_data", u_if.tx_data, m_cur);
      check_eq("fifo_count", fifo_count, m_q.size());
      check_eq("overflow", overflow, m_ovf);
      check_eq("drop_count", drop_count, m_drops);
      check_eq("busy", busy, m_valid || m_esc2 || m_sync || (m_q.size() != 0));
   endtask

   // One clock: inputs are already set at the negedge; record a transfer, update model, check
   task automatic step();
      #1;
      if (u_if.tx_valid && u_if.tx_ready) dut_wire.push_back(u_if.tx_data);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic cyc(input bit s, input bit e, input logic [7:0] d, input bit c);
      sync_req = s; evt_valid = e; evt_data = d; clr = c;
      step();
      sync_req = 0; evt_valid = 0; clr = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0);
   endtask

   task automatic clear_logs();
      dut_wire.delete();
      exp_wire.delete();
   endtask

   task automatic check_wire(input string tag, input logic [7:0] exp[$]);
      check_eq({tag, "_len"}, dut_wire.size(), exp.size());
      for (int i = 0; i < exp.size() && i < dut_wire.size(); i++)
         check_eq(tag, dut_wire[i], exp[i]);
   endtask

   initial begin
      logic [7:0] e[$];
      rstn = 0; sync_req = 0; evt_valid = 0; evt_data = 0; clr = 0;
      u_if.tx_ready = 1;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_tx_valid", u_if.tx_valid, 0);
      check_eq("rst_tx_data", u_if.tx_data, 0);
      check_eq("rst_fifo_count", fifo_count, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_drop_count", drop_count, 0);
      check_eq("rst_busy", busy, 0);
      rstn = 1;
      idle(2);

      // Single event, ready high
      clear_logs();
      cyc(0, 1, 8'h3A, 0);
      idle(1);
      check_eq("t1_valid", u_if.tx_valid, 1);
      check_eq("t1_data", u_if.tx_data, 8'h3A);
      idle(4);
      e = '{8'h3A};
      check_wire("t1_wire", e);
      check_eq("t1_count", fifo_count, 0);
      check_eq("t1_busy", busy, 0);

      // Simultaneous sync and event with ready low
      clear_logs();
      u_if.tx_ready = 0;
      cyc(1, 1, 8'h12, 0);
      idle(3);
      check_eq("t2_hold_data", u_if.tx_data, 8'hFF);
      check_eq("t2_hold_valid", u_if.tx_valid, 1);
      u_if.tx_ready = 1;
      idle(6);
      e = '{8'hFF, 8'h12};
      check_wire("t2_wire", e);

      // Overflow with ready low: first byte goes into SEND, 01..08 fill the FIFO, 09 drops
      clear_logs();
      u_if.tx_ready = 0;
      for (int i = 0; i < 10; i++) cyc(0, 1, 8'(i), 0);
      check_eq("t3_count", fifo_count, 8);
      check_eq("t3_overflow", overflow, 1);
      check_eq("t3_drops", drop_count, 1);
      u_if.tx_ready = 1;
      idle(30);
      e = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      check_wire("t3_wire", e);
      cyc(0, 0, 8'h00, 1);
      check_eq("t3_clr_overflow", overflow, 0);
      check_eq("t3_clr_drops", drop_count, 0);

      // Drop counter saturation and drop-wins-over-clear
      u_if.tx_ready = 0;
      for (int i = 0; i < 270; i++) cyc(0, 1, 8'(i), 0);
      check_eq("t3b_saturate", drop_count, 255);
      cyc(0, 1, 8'hAA, 1);
      check_eq("t3b_drop_clr_cnt", drop_count, 1);
      check_eq("t3b_drop_clr_ovf", overflow, 1);
      u_if.tx_ready = 1;
      idle(30);
      cyc(0, 0, 8'h00, 1);

      // Sync coalescing while an event is in flight
      clear_logs();
      u_if.tx_ready = 0;
      cyc(0, 1, 8'h40, 0);
      idle(1);
      repeat (3) cyc(1, 0, 8'h00, 0);
      cyc(0, 1, 8'h41, 0);
      u_if.tx_ready = 1;
      idle(12);
      e = '{8'h40, 8'hFF, 8'h41};
      check_wire("t4_wire", e);

      // Reset during SEND with three queued entries
      u_if.tx_ready = 0;
      cyc(0, 1, 8'h01, 0);
      idle(1);
      for (int i = 2; i <= 4; i++) cyc(0, 1, 8'(i), 0);
      check_eq("t5_pre_count", fifo_count, 3);
      rstn = 0;
      #1;
      check_eq("t5_rst_valid", u_if.tx_valid, 0);
      check_eq("t5_rst_count", fifo_count, 0);
      check_eq("t5_rst_busy", busy, 0);
      model_reset();
      @(negedge clk);
      rstn = 1;
      u_if.tx_ready = 1;
      clear_logs();
      idle(10);
      check_eq("t5_no_stale", dut_wire.size(), 0);

`ifdef UART_MSG_SCHEDULER_ESCAPE_EN
      // Escaped event with a sync raised during the escape prefix
      clear_logs();
      cyc(0, 1, 8'hFF, 0);
      u_if.tx_ready = 0;
      cyc(0, 1, 8'h05, 0);
      cyc(1, 0, 8'h00, 0);
      u_if.tx_ready = 1;
      idle(15);
      e = '{8'hFE, 8'hDF, 8'hFF, 8'h05};
      check_wire("t6_wire", e);
`endif

      // Randomized traffic against the model
      clear_logs();
      for (int i = 0; i < 3000; i++) begin
         u_if.tx_ready = ($urandom_range(0, 9) < 6);
         cyc($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 35,
             8'($urandom_range(0, 255)), $urandom_range(0, 99) < 5);
      end
      u_if.tx_ready = 1;
      idle(40);
      check_wire("rand_wire", exp_wire);
      check_eq("rand_drained", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
